// File: rtl/count_event_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_event_pkg
// Description : Shared event kinds and default parameters for count_event_fifo
// Revision    : 1.0 - initial release
// ============================================================================
package count_event_pkg;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_WRAP   = 2'd1,
    EV_THRESH = 2'd2
  } ev_kind_e;

  localparam int DEF_BITWIDTH = 4;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_TSW      = 16;

endpackage
`default_nettype wire

// File: rtl/count_event_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Show-ahead synchronous FIFO with wrap-bit pointers
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import count_event_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW:0]      w_diff;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop frees the head slot on this edge, so a full FIFO can still accept
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign w_diff = r_wr_ptr - r_rd_ptr;
  assign level  = LW'(w_diff);
  assign rdata  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !rst) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/count_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : count_event_fifo
// Description : Detects wrap / threshold events on a down-counter value and
//               queues them with timestamps behind a valid/ready port
// Revision    : 1.0 - initial release
// ============================================================================
module count_event_fifo
  import count_event_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int TSW      = DEF_TSW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BITWIDTH-1:0]        indata,
  input  logic [BITWIDTH-1:0]        thresh,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output ev_kind_e                   ev_kind,
  output logic [BITWIDTH-1:0]        ev_value,
  output logic [TSW-1:0]             ev_time,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int EW = 2 + BITWIDTH + TSW;

  logic [TSW-1:0]      r_ts;
  logic [BITWIDTH-1:0] r_prev;
  logic                r_prev_vld;
  logic                r_overflow;
  ev_kind_e            w_kind;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [EW-1:0]       w_wdata;
  logic [EW-1:0]       w_rdata;

  // r_prev_vld masks the first edge after reset, when the upstream counter
  // jumps from its reset value and must not read as a wrap
  always_comb begin
    w_kind = EV_NONE;
    if (r_prev_vld) begin
      if (r_prev == '0 && indata == '1) begin
        w_kind = EV_WRAP;
      end else if (r_prev > thresh && indata <= thresh) begin
        w_kind = EV_THRESH;
      end
    end
  end

  assign w_push  = !rst && (w_kind != EV_NONE);
  assign w_pop   = !w_empty && ev_ready;
  assign w_wdata = {w_kind, indata, r_ts};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts       <= '0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ts       <= r_ts + 1'b1;
      r_prev     <= indata;
      r_prev_vld <= 1'b1;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  assign ev_valid = !w_empty;
  assign ev_kind  = ev_kind_e'(w_rdata[EW-1 -: 2]);
  assign ev_value = w_rdata[TSW +: BITWIDTH];
  assign ev_time  = w_rdata[TSW-1:0];
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_count_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_count_event_fifo
// Description : Self-checking bench for count_event_fifo (table, directed,
//               randomized against a queue-based reference model)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_event_fifo;
  import count_event_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  indata = 4'h0;
  logic [3:0]  thresh = 4'h0;
  logic        ev_ready = 1'b0;
  logic        ev_valid;
  ev_kind_e    ev_kind;
  logic [3:0]  ev_value;
  logic [15:0] ev_time;
  logic [2:0]  level;
  logic        overflow;

  count_event_fifo #(.BITWIDTH(4), .DEPTH(DEPTH), .TSW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .indata   (indata),
    .thresh   (thresh),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_kind  (ev_kind),
    .ev_value (ev_value),
    .ev_time  (ev_time),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: event list as a bounded queue, time as a plain counter
  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  val;
    logic [15:0] t;
  } ent_t;

  ent_t       mq[$];
  int         m_ts   = 0;
  logic [3:0] m_prev = 4'h0;
  bit         m_pvld = 1'b0;
  bit         m_ovf  = 1'b0;

  task automatic model_edge(input bit r, input logic [3:0] ind, input logic [3:0] thr, input bit rdy);
    bit         popped;
    logic [1:0] kind;
    if (r) begin
      mq.delete();
      m_ts = 0; m_prev = 4'h0; m_pvld = 1'b0; m_ovf = 1'b0;
      return;
    end
    popped = (mq.size() > 0) && rdy;
    kind = 2'd0;
    if (m_pvld) begin
      if (m_prev == 4'd0 && ind == 4'd15) kind = 2'd1;
      else if (m_prev > thr && ind <= thr) kind = 2'd2;
    end
    if (popped) void'(mq.pop_front());
    if (kind != 2'd0) begin
      if (mq.size() < DEPTH) mq.push_back('{kind: kind, val: ind, t: 16'(m_ts)});
      else m_ovf = 1'b1;
    end
    m_prev = ind;
    m_pvld = 1'b1;
    m_ts   = (m_ts + 1) % 65536;
  endtask

  task automatic compare_model();
    ent_t h;
    h = '0;
    if (mq.size() > 0) h = mq[0];
    chk("m_valid", ev_valid, (mq.size() != 0));
    chk("m_level", level, mq.size());
    chk("m_overflow", overflow, m_ovf);
    chk("m_kind", ev_kind, h.kind);
    chk("m_value", ev_value, h.val);
    chk("m_time", ev_time, h.t);
  endtask

  task automatic cycle(input bit r, input logic [3:0] ind, input logic [3:0] thr, input bit rdy);
    rst = r; indata = ind; thresh = thr; ev_ready = rdy;
    @(posedge clk);
    model_edge(r, ind, thr, rdy);
    #1;
    compare_model();
  endtask

  typedef struct {
    bit          r;
    logic [3:0]  ind;
    logic [3:0]  thr;
    bit          rdy;
    bit          v;
    logic [1:0]  k;
    logic [3:0]  val;
    logic [15:0] t;
    logic [2:0]  lvl;
    bit          ovf;
  } vec_t;

  vec_t tbl[10];

  initial begin : main
    logic [15:0] exp_t4 [4];
    logic [1:0]  exp_k4 [4];
    int          rdy_pct;
    logic [3:0]  cnt;
    logic [3:0]  thr_r;

    // thresh=2: first-edge suppression, THRESH at 3->2, WRAP at 0->F, drain
    tbl[0] = '{1, 4'hF, 4'd2, 0, 0, 2'd0, 4'h0, 16'd0, 3'd0, 0};
    tbl[1] = '{0, 4'hF, 4'd2, 0, 0, 2'd0, 4'h0, 16'd0, 3'd0, 0};
    tbl[2] = '{0, 4'h3, 4'd2, 0, 0, 2'd0, 4'h0, 16'd0, 3'd0, 0};
    tbl[3] = '{0, 4'h2, 4'd2, 0, 1, 2'd2, 4'h2, 16'd2, 3'd1, 0};
    tbl[4] = '{0, 4'h1, 4'd2, 0, 1, 2'd2, 4'h2, 16'd2, 3'd1, 0};
    tbl[5] = '{0, 4'h0, 4'd2, 0, 1, 2'd2, 4'h2, 16'd2, 3'd1, 0};
    tbl[6] = '{0, 4'hF, 4'd2, 0, 1, 2'd2, 4'h2, 16'd2, 3'd2, 0};
    tbl[7] = '{0, 4'hF, 4'd2, 1, 1, 2'd1, 4'hF, 16'd5, 3'd1, 0};
    tbl[8] = '{0, 4'hF, 4'd2, 1, 0, 2'd0, 4'h0, 16'd0, 3'd0, 0};
    tbl[9] = '{0, 4'hF, 4'd2, 1, 0, 2'd0, 4'h0, 16'd0, 3'd0, 0};

    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].r; indata = tbl[i].ind; thresh = tbl[i].thr; ev_ready = tbl[i].rdy;
      @(posedge clk);
      model_edge(tbl[i].r, tbl[i].ind, tbl[i].thr, tbl[i].rdy);
      #1;
      chk("tbl_valid", ev_valid, tbl[i].v);
      chk("tbl_kind", ev_kind, tbl[i].k);
      chk("tbl_value", ev_value, tbl[i].val);
      chk("tbl_time", ev_time, tbl[i].t);
      chk("tbl_level", level, tbl[i].lvl);
      chk("tbl_overflow", overflow, tbl[i].ovf);
    end

    // Reset then idle at all-ones: nothing may be queued
    for (int i = 0; i < 3; i++) cycle(1, 4'hF, 4'd8, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 4'hF, 4'd8, 0);
      chk("idle_valid", ev_valid, 0);
      chk("idle_level", level, 0);
    end

    // Full count 15..0..15 with consumer always ready
    cycle(1, 4'hF, 4'd8, 1);
    for (int k = 0; k <= 16; k++) begin
      cycle(0, 4'(15 - k), 4'd8, 1);
      if (k == 7) begin
        chk("cnt_thr_valid", ev_valid, 1);
        chk("cnt_thr_kind", ev_kind, EV_THRESH);
        chk("cnt_thr_value", ev_value, 8);
        chk("cnt_thr_time", ev_time, 7);
      end
      if (k == 16) begin
        chk("cnt_wrap_kind", ev_kind, EV_WRAP);
        chk("cnt_wrap_value", ev_value, 15);
        chk("cnt_wrap_time", ev_time, 16);
      end
    end

    // Five wraps with no consumer: saturate and overflow
    cycle(1, 4'hF, 4'd15, 0);
    for (int i = 0; i <= 80; i++) cycle(0, 4'(15 - i), 4'd15, 0);
    chk("ovf_level", level, 4);
    chk("ovf_sticky", overflow, 1);
    for (int j = 0; j < 4; j++) begin
      chk("ovf_drain_kind", ev_kind, EV_WRAP);
      chk("ovf_drain_time", ev_time, 16 * (j + 1));
      cycle(0, 4'hF, 4'd15, 1);
    end
    chk("ovf_drained", ev_valid, 0);
    chk("ovf_still_set", overflow, 1);

    // Full FIFO with simultaneous pop and new THRESH push
    cycle(1, 4'hF, 4'd8, 0);
    for (int i = 0; i <= 39; i++) cycle(0, 4'(15 - i), 4'd8, (i == 39));
    chk("fpp_level", level, 4);
    chk("fpp_overflow", overflow, 0);
    exp_t4 = '{16'd16, 16'd23, 16'd32, 16'd39};
    exp_k4 = '{2'd1, 2'd2, 2'd1, 2'd2};
    for (int j = 0; j < 4; j++) begin
      chk("fpp_kind", ev_kind, exp_k4[j]);
      chk("fpp_time", ev_time, exp_t4[j]);
      cycle(0, 4'h8, 4'd8, 1);
    end

    // Reset on the 0 -> F edge: no wrap across reset, time restarts
    cycle(1, 4'h0, 4'd8, 0);
    cycle(0, 4'h0, 4'd8, 0);
    cycle(0, 4'h0, 4'd8, 0);
    cycle(1, 4'hF, 4'd8, 0);
    cycle(0, 4'hF, 4'd8, 0);
    chk("rst_mid_valid", ev_valid, 0);
    chk("rst_mid_level", level, 0);
    cycle(0, 4'h7, 4'd8, 0);
    chk("rst_mid_time", ev_time, 1);
    chk("rst_mid_kind", ev_kind, EV_THRESH);

    // Head stable under backpressure, then popped
    for (int i = 0; i < 5; i++) begin
      cycle(0, 4'h7, 4'd8, 0);
      chk("hold_kind", ev_kind, EV_THRESH);
      chk("hold_value", ev_value, 7);
      chk("hold_time", ev_time, 1);
    end
    cycle(0, 4'h7, 4'd8, 1);
    chk("hold_popped", ev_valid, 0);

    // Randomized: counter-like stepping, occasional jumps, varying backpressure
    cnt = 4'hF;
    thr_r = 4'd8;
    rdy_pct = 50;
    cycle(1, cnt, thr_r, 0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) thr_r = 4'($urandom_range(0, 15));
      if (i % 500 == 0) rdy_pct = (i / 500 % 3 == 0) ? 10 : ((i / 500 % 3 == 1) ? 50 : 90);
      if ($urandom_range(0, 9) == 0) cnt = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 9) < 7) cnt = cnt - 4'd1;
      cycle(($urandom_range(0, 299) == 0), cnt, thr_r, ($urandom_range(0, 99) < rdy_pct));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/count_event_fifo.md
Name: count_event_fifo

Overview:
- Downstream consumer of the parameterised down-counter's `outdata`. It samples the counter value every cycle and detects two events: underflow wrap and downward threshold crossing.
- Each event is tagged with a free-running timestamp and buffered in a small show-ahead FIFO. A valid/ready port drains the FIFO to the test-bench scoreboard or a later logging stage.

Parameters:
- BITWIDTH, 4, width of the monitored counter value; matches the upstream counter's width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- TSW, 16, timestamp width.

Ports:
- clk  input  1  sole clock; one clock; reset is synchronous and active-high.
- rst  input  1  synchronous active-high reset, sampled on posedge clk.
- indata  input  BITWIDTH  counter value from the upstream down-counter.
- thresh  input  BITWIDTH  threshold for crossing detection; quasi-static.
- ev_valid  output  1  FIFO non-empty.
- ev_ready  input  1  consumer accepts head entry.
- ev_kind  output  2  head entry kind (package enum).
- ev_value  output  BITWIDTH  indata value that caused the event.
- ev_time  output  TSW  timestamp of the sampling edge.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow  output  1  sticky; an event was dropped.

Behaviour:
- Reset (rst=1 at posedge): on the same edge, clear the following.
  - ev_valid=0, level=0, overflow=0.
  - Timestamp counter to 0; prev register to 0; prev_vld to 0.
  - FIFO pointers. FIFO contents are don't-care.
  - ev_kind/ev_value/ev_time read as 0 while empty.
- Timestamp: increments by 1 every non-reset cycle and wraps modulo 2**TSW.
- Sampling: every non-reset edge, prev <= indata and prev_vld <= 1. Detection is combinational on (prev, indata) and is qualified by prev_vld.
- First edge after reset: compare is suppressed. The upstream counter reset to all-ones must never appear as a wrap.
- WRAP: prev == 0 and indata == all-ones.
- THRESH: prev > thresh and indata <= thresh. Unsigned compare.
- WRAP and THRESH are mutually exclusive by construction: prev=0 cannot exceed thresh.
- No event when indata == prev (counter disabled).
- Push: a detected event is written at the same edge that sampled indata. The entry is {kind, indata, timestamp-before-increment}. ev_valid rises in the following cycle if the FIFO was empty, giving 1-cycle latency from indata change to ev_valid.
- Pop: occurs when ev_valid && ev_ready at posedge. The head advances, and the next entry is visible in the next cycle.
- Stability: head fields are stable while ev_valid && !ev_ready.
- Full + push + pop on the same edge: both happen, level stays DEPTH, no overflow.
- Full + push without pop: event dropped and overflow <= 1. overflow is cleared only by rst.
- Empty + push + pop: no pop occurs, because ev_valid=0.
- Ordering: strict FIFO. Timestamps within the FIFO are non-decreasing modulo wrap.
- Reset mid-operation: all pending events are discarded and no event is generated across the reset boundary.
- Non-power-of-two DEPTH: rejected at elaboration with $error.

Decomposition:
- Package count_event_pkg:
  - typedef enum logic[1:0] ev_kind_e {EV_NONE=0, EV_WRAP=1, EV_THRESH=2}; value 3 reserved.
  - Default-parameter localparams.
- Sub-module sync_fifo #(WIDTH, DEPTH):
  - Show-ahead, with push/pop/full/empty/level.
  - Pointers carry an extra wrap bit.
  - count_event_fifo instantiates it with WIDTH = 2+BITWIDTH+TSW.

Test Plan (BITWIDTH=4, DEPTH=4, TSW=16):
1. Reset 3 cycles, then indata held 4'hF for 10 cycles -> ev_valid=0, level=0, overflow=0 throughout.
2. thresh=8, ev_ready=1, indata counts 15→0→15, one step per cycle starting at t=0:
   - THRESH entry (value 8) has ev_time=7, with ev_valid high the next cycle.
   - WRAP entry (value 15) has ev_time=16.
3. ev_ready=0, drive five full wraps -> level saturates at 4 and overflow=1 after the 5th wrap. Drain the FIFO -> 4 WRAP entries with strictly increasing ev_time and correct order; overflow remains 1.
4. FIFO full, ev_ready=1 on the same edge as a new THRESH event -> level stays 4, overflow stays 0, and the new entry appears last.
5. indata=0, then rst=1 on the edge where indata becomes 4'hF, then rst=0 with indata held -> no WRAP entry, level=0, timestamp restarts at 0.
6. One entry pending, ev_ready=0 for 5 cycles while the counter is idle -> ev_kind/ev_value/ev_time unchanged. ev_ready=1 -> popped, ev_valid=0 the next cycle.
